booth_mult_ctrl: RTL and testbench
==================================

Name: booth_mult_ctrl

Overview:
Sequential radix-2 Booth multiplier controller for 4-bit signed operands. It latches two operands on a start handshake and runs four add/subtract-and-shift iterations through one instance of the team's existing 4-bit `addsub` adder/subtractor. It then presents an 8-bit signed product with a one-cycle done pulse. It is the sequencing layer that turns the combinational add/sub datapath into the lab's multiplier.

Parameters:
- N, 4, operand width and iteration count. Only 4 is supported because it matches the `addsub` width; any other value is a synthesis-time error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; sampled only in IDLE
- a  in  4  multiplicand M, two's complement
- b  in  4  multiplier Q, two's complement
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when the product is valid
- product  out  8  signed product {A,Q}; held until the next accepted start

Behaviour:
- Reset:
  - Applies on any edge with rst=1, regardless of state, including mid-operation.
  - State goes to IDLE; busy=0, done=0, product=0.
  - Internal registers A, Q, Q_1, M and count all go to 0.
- States:
  - IDLE:
    - start=1 at edge k: M←a, Q←b, A←0, Q_1←0, count←0, state→CALC.
    - Otherwise the state holds.
  - CALC: one Booth iteration per edge, at edges k+1 through k+4.
    - {Q0,Q_1}=01: add. addsub inputs A, M, control=0.
    - {Q0,Q_1}=10: subtract. addsub inputs A, M, control=1.
    - 00 or 11: pass-through; R=A and addsub is unused.
    - Then arithmetic right shift: {A,Q,Q_1} ← {s, R, Q}, where s is the corrected sign bit.
    - count increments each iteration. When count reaches 3 (the 4th iteration), state→DONE.
  - DONE: lasts one cycle, then state→IDLE unconditionally. start is ignored in DONE.
- Corrected sign bit s, used because the 4-bit accumulator can overflow (e.g. A−(−8)):
  - ovf = (A[3] == (M[3]^control)) && (R[3] != A[3]).
  - s = R[3] ^ ovf.
  - When R=A (pass-through), s=A[3].
- Outputs:
  - busy=1 from edge k to edge k+4, i.e. in CALC.
  - done=1 exactly one cycle, from edge k+4 to edge k+5, i.e. in DONE.
  - product is registered from {A,Q} at edge k+4 and holds through IDLE.
  - Latency is 4 cycles from start acceptance to done.
- The `addsub` co output is not used for the result; the sign comes only from s.
- start held high continuously: a new operation is accepted at the first IDLE edge after DONE, so one operation every 6 cycles.
- Operands a and b are don't-care except at the accepting edge.
- Full range is exact: −8×−8=+64 and −8×7=−56. No saturation is needed because the 8-bit result always fits.

Decomposition:
- Shared package `mult_pkg`:
  - State encoding: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - N=4 and PROD_W=2N.
  - Booth-pair constants: ADD=2'b01, SUB=2'b10.
- One sub-module: the existing `addsub`, instantiated once.
  - Ports are bit-level: a3..a0, b3..b0, control, r3..r0, co.
  - A drives a3..a0, M drives b3..b0, R is r3..r0, co is left unconnected.
- All state, counter and shift logic lives in `booth_mult_ctrl`.

Test Plan:
1. Reset for 2 cycles, then start with a=0011, b=0101 → busy for 4 cycles, done pulse, product=0x0F (15); product stays 0x0F for 3 more idle cycles.
2. a=1101 (−3), b=0101 (5) → product=0xF1 (−15). Then a=0111 (7), b=1000 (−8) → product=0xC8 (−56).
3. a=1000, b=1000 (−8×−8) → product=0x40 (+64); confirms the sign correction on A−M overflow.
4. a=0000, b=1111 and a=1111, b=1111 → 0x00 and 0x01. Pulse start again mid-CALC with different operands → ignored, product and latency unchanged.
5. start accepted, then rst=1 at the 2nd CALC edge → next cycle busy=0, done=0, product=0. A new start with a=0010, b=0011 then gives 0x06 with normal 4-cycle latency.
6. start held high for 20 cycles with a=0110, b=0110 → done every 6 cycles, each product=0x24, and start is never accepted in DONE.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared constants, state encoding and Booth-pair codes for the multiplier
package mult_pkg;
  localparam int N = 4;
  localparam int PROD_W = 2 * N;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;
endpackage

// File: rtl/addsub.sv
// addsub: 4-bit ripple adder/subtractor, r = control ? a - b : a + b
module addsub (
  input  logic a3, a2, a1, a0,
  input  logic b3, b2, b1, b0,
  input  logic control,
  output logic r3, r2, r1, r0,
  output logic co
);
  logic [4:0] sum;
  assign sum = {1'b0, a3, a2, a1, a0} + {1'b0, {b3, b2, b1, b0} ^ {4{control}}} + {4'd0, control};
  assign {co, r3, r2, r1, r0} = sum;
endmodule

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequential radix-2 Booth multiplier for 4-bit signed operands
module booth_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        a,
  input  logic [3:0]        b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);
  if (N != 4) begin : g_bad_width
    $error("booth_mult_ctrl supports only N=4");
  end
  state_t state, state_next;
  logic [3:0] acc, q, m, r, r_as;
  logic       q_1, ctrl, use_as, ovf, s, last;
  logic [1:0] cnt;
  logic [1:0] pair;
  assign pair   = {q[0], q_1};
  assign ctrl   = pair == SUB;
  assign use_as = pair == ADD || pair == SUB;
  assign r      = use_as ? r_as : acc;
  // A 4-bit accumulator can overflow (e.g. A - (-8)); recover the true sign for the shift-in
  assign ovf    = use_as && (acc[3] == (m[3] ^ ctrl)) && (r[3] != acc[3]);
  assign s      = r[3] ^ ovf;
  assign last   = cnt == 2'd3;
  assign busy   = state == CALC;
  assign done   = state == DONE;
  addsub u_addsub (
    .a3(acc[3]), .a2(acc[2]), .a1(acc[1]), .a0(acc[0]),
    .b3(m[3]), .b2(m[2]), .b1(m[1]), .b0(m[0]),
    .control(ctrl),
    .r3(r_as[3]), .r2(r_as[2]), .r1(r_as[1]), .r0(r_as[0]),
    .co()
  );
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? CALC : IDLE;
      CALC:    state_next = last ? DONE : CALC;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE && start) begin
      m   <= a;
      q   <= b;
      acc <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
    end else if (state == CALC) begin
      {acc, q, q_1} <= {s, r, q};
      cnt           <= cnt + 2'd1;
      if (last) product <= {s, r, q[3:1]};
    end
  end
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: directed table-driven checks plus multi-cycle corner sequences
module tb_booth_mult_ctrl;
  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] a, b;
  logic busy, done;
  logic [7:0] product;
  int tests = 0, fails = 0;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[7];
  booth_mult_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp,
                        input string name, input bit pulse_mid);
    int lat;
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'hx;
    b = 4'hx;
    chk({name, " busy"}, int'(busy), 1);
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (pulse_mid && lat == 1) begin
        a = 4'd7;
        b = 4'd7;
        start = 1'b1;
      end else start = 1'b0;
    end
    chk({name, " latency"}, lat, 4);
    chk({name, " product"}, int'(product), int'(exp));
    @(negedge clk);
    chk({name, " done pulse"}, int'(done), 0);
  endtask
  initial begin
    int done_cnt, last_done;
    vecs[0] = '{4'b0011, 4'b0101, 8'h0F};
    vecs[1] = '{4'b1101, 4'b0101, 8'hF1};
    vecs[2] = '{4'b0111, 4'b1000, 8'hC8};
    vecs[3] = '{4'b1000, 4'b1000, 8'h40};
    vecs[4] = '{4'b0000, 4'b1111, 8'h00};
    vecs[5] = '{4'b1111, 4'b1111, 8'h01};
    vecs[6] = '{4'b0010, 4'b0011, 8'h06};
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset product", int'(product), 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
    run_op(4'b0011, 4'b0101, 8'h0F, "hold", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold idle%0d", i), int'(product), 8'h0F);
    end
    run_op(4'b1101, 4'b0101, 8'hF1, "mid start", 1'b1);
    chk("mid start not accepted", int'(busy), 0);
    @(negedge clk);
    a = 4'b0111;
    b = 4'b0111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst product", int'(product), 0);
    run_op(4'b0010, 4'b0011, 8'h06, "post rst", 1'b0);
    @(negedge clk);
    a = 4'b0110;
    b = 4'b0110;
    start = 1'b1;
    done_cnt = 0;
    last_done = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk($sformatf("stream product%0d", done_cnt), int'(product), 8'h24);
        chk($sformatf("stream gap%0d", done_cnt), i - last_done, 5 + (last_done != 0 ? 1 : 0));
        last_done = i;
      end else if (last_done == i - 1 && last_done != 0) begin
        chk($sformatf("stream idle after done%0d", done_cnt), int'(busy), 0);
      end
    end
    start = 1'b0;
    chk("stream done count", done_cnt, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
